operation_sequencer: RTL and testbench

//  Initiator for operation_machine. Holds a small program of micro-ops (produced by the eq HLS flow).
//  On start, issues the ops one at a time: operand, index1, index2 and value.

---
 rtl/operation_pkg.sv | 33 +++
 rtl/operation_prog_mem.sv | 27 ++
 rtl/operation_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_operation_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operation_pkg.sv
// Shared types for the operation sequencer/machine pair: opcodes, error codes
// and the packed micro-op instruction word.
package operation_pkg;

  localparam int N       = 32;
  localparam int Q       = 16;
  localparam int STACK   = 5;
  localparam int IW      = $clog2(STACK) + 2;
  localparam int INSTR_W = 1 + 2 + 2 * IW + N;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_MUL  = 2'd2,
    OP_NEG  = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_INDEX = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_RUN_OFF   = 2'd3
  } err_code_e;

  typedef struct packed {
    logic          last;
    opcode_e       opcode;
    logic [IW-1:0] idx1;
    logic [IW-1:0] idx2;
    logic [N-1:0]  value;
  } instr_t;

endpackage

// File: rtl/operation_prog_mem.sv
// Micro-op program store: one synchronous write port, one registered read port
// with read enable so the fetched word stays put while an op is in flight.
module operation_prog_mem #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 45,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/operation_sequencer.sv
// Issues a stored micro-op program to operation_machine one op at a time,
// waiting on op_done after each and reporting the final result or an error.
module operation_sequencer
  import operation_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  parameter  int TIMEOUT    = 255,
  localparam int PAW        = $clog2(PROG_DEPTH),
  localparam int TW         = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [PAW-1:0]     prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  output logic               busy,
  output logic [1:0]         operand,
  output logic [IW-1:0]      index1,
  output logic [IW-1:0]      index2,
  output logic [N-1:0]       value,
  output logic               op_valid,
  input  logic               op_done,
  input  logic [N-1:0]       op_result,
  output logic [N-1:0]       result,
  output logic               result_valid,
  output logic               error,
  output logic [1:0]         error_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_ISSUE, S_WAIT, S_FINISH
  } state_e;

  localparam logic [IW-1:0] STACK_LIM = IW'(STACK);

  state_e        state_q, state_d;
  logic [PAW-1:0] pc_q, pc_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic          busy_q, busy_d;
  logic          op_valid_q, op_valid_d;
  opcode_e       operand_q, operand_d;
  logic [IW-1:0] index1_q, index1_d, index2_q, index2_d;
  logic [N-1:0]  value_q, value_d;
  logic [N-1:0]  last_res_q, last_res_d, result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          error_q, error_d;
  err_code_e     error_code_q, error_code_d;

  logic [INSTR_W-1:0] mem_rdata;
  instr_t             instr;
  logic               bad_index;

  operation_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we & ~busy_q),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (state_q == S_FETCH),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign instr     = instr_t'(mem_rdata);
  assign bad_index = (instr.idx1 >= STACK_LIM) ||
                     (((instr.opcode == OP_ADD) || (instr.opcode == OP_MUL)) &&
                      (instr.idx2 >= STACK_LIM));
  assign timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    timer_d        = timer_q;
    busy_d         = busy_q;
    op_valid_d     = op_valid_q;
    operand_d      = operand_q;
    index1_d       = index1_q;
    index2_d       = index2_q;
    value_d        = value_q;
    last_res_d     = last_res_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = error_q;
    error_code_d   = error_code_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FETCH;
          pc_d         = '0;
          error_d      = 1'b0;
          error_code_d = ERR_NONE;
          busy_d       = 1'b1;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (bad_index) begin
          error_d      = 1'b1;
          error_code_d = ERR_BAD_INDEX;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Unused index/value fields are forced to zero so the machine sees clean inputs.
        op_valid_d = 1'b1;
        operand_d  = instr.opcode;
        index1_d   = (instr.opcode == OP_LOAD) ? '0 : instr.idx1;
        index2_d   = ((instr.opcode == OP_ADD) || (instr.opcode == OP_MUL)) ? instr.idx2 : '0;
        value_d    = (instr.opcode == OP_LOAD) ? instr.value : '0;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (op_done) begin
          op_valid_d = 1'b0;
          last_res_d = op_result;
          if (instr.last) begin
            state_d = S_FINISH;
          end else if (pc_q == PAW'(PROG_DEPTH - 1)) begin
            error_d      = 1'b1;
            error_code_d = ERR_RUN_OFF;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            pc_d    = pc_q + PAW'(1);
            state_d = S_FETCH;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TW'(TIMEOUT)) begin
            error_d      = 1'b1;
            error_code_d = ERR_TIMEOUT;
            op_valid_d   = 1'b0;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end
      S_FINISH: begin
        result_d       = last_res_q;
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      timer_q        <= '0;
      busy_q         <= 1'b0;
      op_valid_q     <= 1'b0;
      operand_q      <= OP_LOAD;
      index1_q       <= '0;
      index2_q       <= '0;
      value_q        <= '0;
      last_res_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      timer_q        <= timer_d;
      busy_q         <= busy_d;
      op_valid_q     <= op_valid_d;
      operand_q      <= operand_d;
      index1_q       <= index1_d;
      index2_q       <= index2_d;
      value_q        <= value_d;
      last_res_q     <= last_res_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      error_code_q   <= error_code_d;
    end
  end

  assign busy         = busy_q;
  assign op_valid     = op_valid_q;
  assign operand      = operand_q;
  assign index1       = index1_q;
  assign index2       = index2_q;
  assign value        = value_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign error_code   = error_code_q;

endmodule

// File: tb/tb_operation_sequencer.sv
// Bench for operation_sequencer: a stack-machine responder, a program-walk model
// of the expected issue stream, and one compare process fed by end-of-test requests.
module tb_operation_sequencer;
  import operation_pkg::*;

  localparam int PD = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               prog_we = 1'b0;
  logic [3:0]         prog_addr = '0;
  logic [INSTR_W-1:0] prog_wdata = '0;
  logic               start = 1'b0;
  logic               busy, op_valid, result_valid, error;
  logic [1:0]         operand, error_code;
  logic [IW-1:0]      index1, index2;
  logic [N-1:0]       value, result;
  logic [N-1:0]       op_result = '0;
  logic               op_done;
  logic               mach_done = 1'b0;
  logic               spur_done = 1'b0;

  assign op_done = mach_done | spur_done;

  always #5 clk = ~clk;

  operation_sequencer dut (
    .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .busy(busy), .operand(operand),
    .index1(index1), .index2(index2), .value(value), .op_valid(op_valid),
    .op_done(op_done), .op_result(op_result), .result(result),
    .result_valid(result_valid), .error(error), .error_code(error_code)
  );

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] i1;
    logic [IW-1:0] i2;
    logic [N-1:0]  val;
  } issue_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model / request state, written only by the main thread
  instr_t     prog [PD];
  issue_t     exp_issue [32];
  int         exp_n = 0;
  int         exp_res_n = 0;
  logic [N-1:0] exp_res_val = '0;
  logic [N-1:0] exp_result_reg = '0;
  int         test_id = 0;
  int         start_edge = -1;
  int         mach_lat = 2;
  bit         withhold = 1'b0;
  bit         hung_flag = 1'b0;
  int         req_seq = 0, req_kind = 0, req_issues = 0, req_nres = 0, req_len = -1;
  int         req_hung = 0;
  logic       req_err = 1'b0;
  logic [1:0] req_code = '0;
  logic [N-1:0] req_result = '0;
  string      req_name = "";

  // Compare-process state
  int cmp_n = 0, fail_n = 0;
  int rd_idx = 0, res_seen = 0, last_len = -1;

  function automatic logic [N-1:0] mach_fn(logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b,
                                           logic [N-1:0] v);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      2'd0:    return v;
      2'd1:    return a + b;
      2'd2:    return p[47:16];
      default: return -a;
    endcase
  endfunction

  function automatic instr_t mk(bit last, opcode_e op, int i1, int i2, logic [N-1:0] v);
    instr_t t;
    t.last = last; t.opcode = op; t.idx1 = IW'(i1); t.idx2 = IW'(i2); t.value = v;
    return t;
  endfunction

  // Walk the program as the sequencer is meant to, recording every op it must issue.
  task automatic build_model();
    logic [N-1:0] stk [STACK];
    int sp, pc;
    bit done;
    instr_t ins;
    issue_t e;
    logic [N-1:0] r;
    sp = 0; pc = 0; done = 0; exp_n = 0; exp_res_n = 0;
    for (int i = 0; i < STACK; i++) stk[i] = '0;
    while (!done) begin
      ins = prog[pc];
      if (int'(ins.idx1) >= STACK ||
          ((ins.opcode == OP_ADD || ins.opcode == OP_MUL) && int'(ins.idx2) >= STACK)) begin
        done = 1;
      end else begin
        e.op  = ins.opcode;
        e.i1  = (ins.opcode == OP_LOAD) ? '0 : ins.idx1;
        e.i2  = (ins.opcode == OP_ADD || ins.opcode == OP_MUL) ? ins.idx2 : '0;
        e.val = (ins.opcode == OP_LOAD) ? ins.value : '0;
        r = mach_fn(e.op, stk[int'(e.i1)], stk[int'(e.i2)], e.val);
        stk[sp] = r;
        sp = (sp + 1) % STACK;
        exp_issue[exp_n] = e;
        exp_n++;
        if (ins.last) begin
          exp_res_n = 1; exp_res_val = r; done = 1;
        end else if (pc == PD - 1) begin
          done = 1;
        end else begin
          pc++;
        end
      end
    end
  endtask

  // Operation machine stand-in: fixed latency, results pushed round-robin onto a stack.
  logic [N-1:0] r_stk [STACK];
  int r_sp = 0, r_cnt = 0;
  bit r_sent = 0;
  initial begin : responder
    logic [N-1:0] r;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || (!busy && !op_valid)) begin
        for (int i = 0; i < STACK; i++) r_stk[i] = '0;
        r_sp = 0;
      end
      if (!reset_n || !op_valid) begin
        mach_done = 1'b0; r_sent = 0; r_cnt = 0;
      end else if (mach_done) begin
        mach_done = 1'b0;
      end else if (!r_sent && !withhold) begin
        if (r_cnt >= mach_lat) begin
          r = mach_fn(operand, r_stk[int'(index1) % STACK], r_stk[int'(index2) % STACK], value);
          op_result = r;
          r_stk[r_sp] = r;
          r_sp = (r_sp + 1) % STACK;
          mach_done = 1'b1;
          r_sent = 1;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h, expected %0h (t%0d, cycle %0d)", name, act, exp, test_id, cyc);
    end
  endtask

  initial begin : compare
    int seen_test, seen_req, cur, len;
    bit prev_v, prev_rv;
    issue_t e;
    seen_test = 0; seen_req = 0; cur = -1; len = 0; prev_v = 0; prev_rv = 0;
    forever begin
      @(negedge clk);
      if (test_id != seen_test) begin
        seen_test = test_id; rd_idx = 0; res_seen = 0; cur = -1;
      end
      if (op_valid && !prev_v) begin
        $display("issue t%0d #%0d op=%0d i1=%0d i2=%0d val=%h", test_id, rd_idx, operand,
                 index1, index2, value);
        if (rd_idx >= exp_n) begin
          chk("unexpected_issue", 64'(rd_idx), 64'(exp_n));
          cur = -1;
        end else begin
          e = exp_issue[rd_idx];
          chk("issue_fields", {20'b0, operand, index1, index2, value},
              {20'b0, e.op, e.i1, e.i2, e.val});
          if (rd_idx == 0) chk("start_latency", 64'(cyc - start_edge), 64'd3);
          cur = rd_idx;
        end
        rd_idx++;
        len = 1;
      end else if (op_valid) begin
        len++;
        if (cur >= 0) begin
          e = exp_issue[cur];
          chk("hold_fields", {20'b0, operand, index1, index2, value},
              {20'b0, e.op, e.i1, e.i2, e.val});
        end
      end
      if (!op_valid && prev_v) last_len = len;
      if (result_valid) begin
        $display("result t%0d = %h", test_id, result);
        if (prev_rv || res_seen >= exp_res_n) chk("extra_result_valid", 64'(res_seen), 64'(exp_res_n));
        else chk("result_pulse", 64'(result), 64'(exp_res_val));
        res_seen++;
      end
      if (req_seq != seen_req) begin
        seen_req = req_seq;
        if (req_kind == 1) begin
          chk({req_name, "_op_valid"}, 64'(op_valid), 64'd0);
          chk({req_name, "_busy"}, 64'(busy), 64'd0);
          chk({req_name, "_fields"}, {20'b0, operand, index1, index2, value}, 64'd0);
          chk({req_name, "_result"}, {31'b0, result_valid, result}, 64'd0);
          chk({req_name, "_error"}, {61'b0, error, error_code}, 64'd0);
        end else begin
          chk({req_name, "_issues"}, 64'(rd_idx), 64'(req_issues));
          chk({req_name, "_results"}, 64'(res_seen), 64'(req_nres));
          chk({req_name, "_busy"}, 64'(busy), 64'd0);
          chk({req_name, "_op_valid"}, 64'(op_valid), 64'd0);
          chk({req_name, "_error"}, 64'(error), 64'(req_err));
          chk({req_name, "_error_code"}, 64'(error_code), 64'(req_code));
          chk({req_name, "_result"}, 64'(result), 64'(req_result));
          if (req_len >= 0) chk({req_name, "_valid_len"}, 64'(last_len), 64'(req_len));
          chk({req_name, "_bounded_wait"}, 64'(req_hung), 64'd0);
        end
      end
      prev_v = op_valid; prev_rv = result_valid;
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask

  task automatic wr(int a, instr_t ins);
    prog[a] = ins;
    prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = ins;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic run_prog();
    build_model();
    if (exp_res_n != 0) exp_result_reg = exp_res_val;
    test_id++;
    tick();
    start = 1'b1; start_edge = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (!busy) ok = 1;
    end
    if (!ok) hung_flag = 1;
    tick(); tick();
  endtask

  task automatic wait_valid(int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (op_valid) ok = 1; else tick();
    end
    if (!ok) hung_flag = 1;
  endtask

  task automatic end_check(string name, int n_iss, int n_res, logic err, logic [1:0] code,
                           logic [N-1:0] res, int len);
    req_name = name; req_kind = 0; req_issues = n_iss; req_nres = n_res; req_err = err;
    req_code = code; req_result = res; req_len = len; req_hung = int'(hung_flag);
    hung_flag = 0;
    req_seq++;
    tick(); tick();
  endtask

  task automatic reset_check(string name);
    req_name = name; req_kind = 1;
    req_seq++;
    tick(); tick();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < PD; i++) prog[i] = mk(1'b1, OP_LOAD, 0, 0, '0);
    reset_n = 1'b0;
    tick(); tick(); tick();
    reset_check("reset");
    reset_n = 1'b1;
    tick();

    // T1: 1.5 * 2.0
    wr(0, mk(1'b0, OP_LOAD, 0, 0, 32'h0001_8000));
    wr(1, mk(1'b0, OP_LOAD, 0, 0, 32'h0002_0000));
    wr(2, mk(1'b1, OP_MUL, 0, 1, '0));
    mach_lat = 2;
    run_prog();
    wait_idle(200);
    end_check("t1", 3, 1, 1'b0, 2'd0, 32'h0003_0000, -1);

    // T2: first index out of range
    wr(0, mk(1'b1, OP_ADD, 5, 0, '0));
    run_prog();
    wait_idle(50);
    end_check("t2", 0, 0, 1'b1, 2'd1, 32'h0003_0000, -1);

    // T3: machine never answers
    wr(0, mk(1'b1, OP_LOAD, 0, 0, 32'h0000_0007));
    withhold = 1'b1;
    run_prog();
    wait_idle(400);
    end_check("t3", 1, 0, 1'b1, 2'd2, 32'h0003_0000, 255);
    withhold = 1'b0;

    // T4: sixteen LOADs with no terminator
    for (int i = 0; i < PD; i++) wr(i, mk(1'b0, OP_LOAD, 0, 0, N'(i + 1) << 16));
    run_prog();
    wait_idle(600);
    end_check("t4", 16, 0, 1'b1, 2'd3, 32'h0003_0000, -1);

    // T5: write and start while running are ignored
    wr(0, mk(1'b0, OP_LOAD, 0, 0, 32'h0001_0000));
    wr(1, mk(1'b0, OP_LOAD, 0, 0, 32'h0002_8000));
    wr(2, mk(1'b1, OP_ADD, 0, 1, '0));
    mach_lat = 6;
    run_prog();
    wait_valid(20);
    tick();
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = mk(1'b1, OP_LOAD, 0, 0, 32'h0000_7777);
    start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_idle(200);
    end_check("t5_run", 3, 1, 1'b0, 2'd0, 32'h0003_8000, -1);
    run_prog();
    wait_idle(200);
    end_check("t5_rerun", 3, 1, 1'b0, 2'd0, 32'h0003_8000, -1);
    run_prog();
    wait_valid(20);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_check("t5_reset");
    reset_n = 1'b1;
    exp_result_reg = '0;
    tick(); tick();
    end_check("t5_abort", 1, 0, 1'b0, 2'd0, 32'h0000_0000, -1);

    // T6: NEG drops idx2; spurious op_done in IDLE and FETCH
    wr(0, mk(1'b0, OP_LOAD, 0, 0, 32'h0001_0000));
    wr(1, mk(1'b0, OP_LOAD, 0, 0, 32'h0003_0000));
    wr(2, mk(1'b0, OP_LOAD, 0, 0, 32'h0000_8000));
    wr(3, mk(1'b1, OP_NEG, 2, 3, '0));
    mach_lat = 1;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    build_model();
    exp_result_reg = exp_res_val;
    test_id++;
    tick();
    start = 1'b1; start_edge = cyc + 1;
    tick();
    start = 1'b0; spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    wait_idle(200);
    end_check("t6", 4, 1, 1'b0, 2'd0, 32'hFFFF_8000, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
